// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative radix-2 restoring integer divider (MIPS DIV/DIVU)
//
// Computes quotient (LO) and remainder (HI) of a_i / b_i over WIDTH cycles.
// The signed form divides magnitudes and then fixes the signs: the quotient
// sign is a^b and the remainder takes the dividend's sign.
// Divide by zero skips the iteration and returns LO = all ones, HI = a_i.
//
// Handshake: a request is accepted on a rising edge where the unit is IDLE
// and start_i & ~annul_i is high. stall_o stays high from the request cycle
// until the last iteration. ready_o pulses for the single DONE cycle, during
// which hi_o/lo_o carry the new result. Outside DONE, hi_o/lo_o show the
// previous result. annul_i abandons a request in IDLE or BUSY. It has no
// effect in DONE.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   start_i   in   1      request a divide
//   signed_i  in   1      1 = signed (DIV), 0 = unsigned (DIVU)
//   annul_i   in   1      flush/exception: abandon request or in-flight divide
//   a_i       in   WIDTH  dividend
//   b_i       in   WIDTH  divisor
//   stall_o   out  1      pipeline hold while the divide is pending
//   ready_o   out  1      one-cycle result-valid pulse
//   hi_o      out  WIDTH  remainder
//   lo_o      out  WIDTH  quotient
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // State register kept in a named enum so checkers can bind to it.
  state_t state_q, state_d;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;      // dividend/quotient shift register
  logic [WIDTH-1:0] rem_q, rem_d;  // partial remainder
  logic [WIDTH-1:0] b_q, b_d;      // divisor magnitude
  logic             qs_q, qs_d;    // negate quotient at the end
  logic             rs_q, rs_d;    // negate remainder at the end
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;    // last delivered result
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  // Magnitudes are only taken for signed requests. The negation wraps
  // modulo 2^WIDTH, so the most negative dividend keeps its bit pattern and
  // is then treated as an unsigned magnitude.
  always_comb begin
    a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // One restoring step. The shifted remainder is held on WIDTH+1 bits. A
  // divisor magnitude above 2^(WIDTH-1) can leave a partial remainder with
  // its top bit set, and that bit must survive the shift.
  always_comb begin
    rem_shift = {rem_q, q_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, b_q};
    rem_ge    = (rem_shift >= {1'b0, b_q});
  end

  // For divide by zero, q_q holds the raw dividend instead of its magnitude.
  always_comb begin
    if (div0_q) begin
      res_lo = '1;
      res_hi = q_q;
    end else begin
      res_lo = qs_q ? -q_q : q_q;
      res_hi = rs_q ? -rem_q : rem_q;
    end
  end

  assign accept = start_i & ~annul_i;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_d     = q_q;
    rem_d   = rem_q;
    b_d     = b_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          qs_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rs_d    = signed_i & a_i[WIDTH-1];
          b_d     = b_mag;
          rem_d   = '0;
          count_d = '0;
          if (b_i == '0) begin
            q_d     = a_i;
            div0_d  = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = a_mag;
            div0_d  = 1'b0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d   = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          q_d     = {q_q[WIDTH-2:0], rem_ge};
          count_d = count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The result appears during DONE itself. The held copy covers all other
  // states, so the outputs never move while BUSY.
  always_comb begin
    ready_o = (state_q == DONE);
    stall_o = ((state_q == IDLE) & accept) | (state_q == BUSY);
    hi_o    = (state_q == DONE) ? res_hi : hi_q;
    lo_o    = (state_q == DONE) ? res_lo : lo_q;
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         signed_i;
  logic         annul_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         stall_o;
  logic         ready_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks;
  int failures;

  // Scoreboard entries are {hi, lo}.
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   prev_hi;
  logic [W-1:0]   prev_lo;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .annul_i  (annul_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Plain wide-integer division. Both operators truncate toward zero, and
  // the remainder follows the dividend's sign, matching DIV/DIVU.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
    longint sa, sb, qq, rr;
    if (b == '0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  // ---------------- driver ----------------
  // Issues a request in the next cycle and follows it to ready_o. Along the
  // way it checks stall_o, that the outputs hold, and the latency.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp_hilo,
                        input int exp_lat, input string name);
    int k;
    logic [2*W-1:0] e;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_idle: ready_o=%b required 0", name, ready_o);
    end
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
    exp_q.push_back(exp_hilo);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      failures++;
      $display("FAIL %s stall_req: stall_o=%b required 1", name, stall_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    k = 1;
    while (ready_o !== 1'b1 && k <= 60) begin
      checks++;
      if (stall_o !== 1'b1 || hi_o !== prev_hi || lo_o !== prev_lo) begin
        failures++;
        $display("FAIL %s busy_hold k=%0d: stall=%b hi=%h lo=%h required stall=1 hi=%h lo=%h",
                 name, k, stall_o, hi_o, lo_o, prev_hi, prev_lo);
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: no ready_o within %0d cycles", name, k);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (k != exp_lat) begin
        failures++;
        $display("FAIL %s latency: got %0d required %0d", name, k, exp_lat);
      end
      checks++;
      if (stall_o !== 1'b0) begin
        failures++;
        $display("FAIL %s stall_done: stall_o=%b required 0", name, stall_o);
      end
      checks++;
      if (lo_o !== e[W-1:0] || hi_o !== e[2*W-1:W]) begin
        failures++;
        $display("FAIL %s result: lo=%h hi=%h required lo=%h hi=%h",
                 name, lo_o, hi_o, e[W-1:0], e[2*W-1:W]);
      end
      prev_lo = e[W-1:0];
      prev_hi = e[2*W-1:W];
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
      failures++;
      $display("FAIL reset_state: stall=%b ready=%b hi=%h lo=%h required all 0",
               stall_o, ready_o, hi_o, lo_o);
    end
    prev_hi = '0;
    prev_lo = '0;
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, "div_overflow");
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, {32'd1, 32'd1}, 33, "divu_big_divisor");
  endtask

  task automatic test_div_zero();
    do_div(32'hDEAD_BEEF, 32'd0, 1'b0, {32'hDEAD_BEEF, 32'hFFFF_FFFF}, 1, "divu_zero");
    do_div(32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1, "div_zero_neg");
  endtask

  task automatic test_annul();
    int k;
    @(negedge clk);
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 1;
    while (k < 10) begin
      @(negedge clk);
      k++;
    end
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL annul_idle: stall=%b ready=%b required 0 0", stall_o, ready_o);
    end
    repeat (30) begin
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0 || hi_o !== prev_hi || lo_o !== prev_lo) begin
        failures++;
        $display("FAIL annul_quiet: ready=%b hi=%h lo=%h required 0 %h %h",
                 ready_o, hi_o, lo_o, prev_hi, prev_lo);
      end
    end
  endtask

  task automatic test_start_annul();
    @(negedge clk);
    a_i = 32'd50; b_i = 32'd5; signed_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL start_annul_stall: stall_o=%b required 0", stall_o);
    end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    repeat (5) begin
      checks++;
      if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
        failures++;
        $display("FAIL start_annul_quiet: stall=%b ready=%b required 0 0", stall_o, ready_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
      failures++;
      $display("FAIL reset_mid: stall=%b ready=%b hi=%h lo=%h required all 0",
               stall_o, ready_o, hi_o, lo_o);
    end
    prev_hi = '0;
    prev_lo = '0;
    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "b2b_first");
    do_div(32'd10, 32'd4, 1'b0, {32'd2, 32'd2}, 33, "b2b_second");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: begin b = $urandom; a = 32'h8000_0000; end
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, ref_div(a, b, s), (b == '0) ? 1 : 33, "random");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_annul();
    test_start_annul();
    test_reset_mid();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
